// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//
// Multi-cycle shift unit for the multicycle MIPS datapath. It sits directly
// downstream of the shifter entry-select and shift-amount-select muxes. A job
// latches an operand, an operation and a shift amount, then moves the working
// register by one bit position per clock until the amount is used up.
//
// Handshake: a job is accepted on a rising edge where start=1 and the unit is
// idle (busy=0). start seen while busy=1, including during the done cycle, is
// dropped rather than queued. done is a one-cycle pulse; result is final while
// done=1 and is held until the next accepted start. Inputs other than start are
// only looked at on the accepting edge.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (aborts any job, no done)
//   start     in   job request, honoured only when idle
//   op        in   3'b000 sll, 001 srl, 010 sra, 011 rotl, 100 rotr,
//                  anything else is a pass-through of data_in
//   data_in   in   operand [DATA_W-1:0]
//   shamt_in  in   shift amount [SHAMT_W-1:0]
//   result    out  working/final register [DATA_W-1:0]
//   busy      out  high while a job is in flight (SHIFT or DONE)
//   done      out  one-cycle pulse, result is final
//   dbg_state out  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module shift_unit_seq #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHAMT_W-1:0] shamt_in,
   output logic [DATA_W-1:0]  result,
   output logic               busy,
   output logic               done,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_SLL  = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SRA  = 3'b010;
   localparam logic [2:0] OP_ROTL = 3'b011;
   localparam logic [2:0] OP_ROTR = 3'b100;

   state_t             state, state_nx;
   logic [DATA_W-1:0]  result_nx;
   logic [SHAMT_W-1:0] count, count_nx;
   logic [2:0]         op_q, op_nx;
   logic               op_valid;

   // One-position step of the latched operation. Amounts at or above DATA_W
   // need no special casing: stepping bit by bit naturally saturates logical
   // shifts, fills sra with the sign, and wraps rotates.
   function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                    input logic [2:0]        o);
      logic [DATA_W-1:0] r;
      r = v;
      case (o)
         OP_SLL:  r = {v[DATA_W-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[DATA_W-1:1]};
         OP_SRA:  r = {v[DATA_W-1], v[DATA_W-1:1]};
         OP_ROTL: r = {v[DATA_W-2:0], v[DATA_W-1]};
         OP_ROTR: r = {v[0], v[DATA_W-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign op_valid = (op <= OP_ROTR);

   always_comb begin
      state_nx  = state;
      result_nx = result;
      count_nx  = count;
      op_nx     = op_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               result_nx = data_in;
               op_nx     = op;
               count_nx  = shamt_in;
               // Zero amount or pass-through op has nothing to shift.
               state_nx  = ((shamt_in != '0) && op_valid) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            result_nx = shift_one(result, op_q);
            count_nx  = count - SHAMT_W'(1);
            if (count == SHAMT_W'(1)) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // busy and done are flopped from the next state so they change together
   // with the state register and have no path from the inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         result <= '0;
         count  <= '0;
         op_q   <= OP_SLL;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         result <= result_nx;
         count  <= count_nx;
         op_q   <= op_nx;
         busy   <= (state_nx != S_IDLE);
         done   <= (state_nx == S_DONE);
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   // ---------------- clock / reset ----------------
   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [2:0]         op = 3'b000;
   logic [DATA_W-1:0]  data_in = '0;
   logic [SHAMT_W-1:0] shamt_in = '0;
   logic [DATA_W-1:0]  result;
   logic               busy;
   logic               done;
   logic [1:0]         dbg_state;

   always #5 clk = ~clk;

   shift_unit_seq #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .data_in   (data_in),
      .shamt_in  (shamt_in),
      .result    (result),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: whole-amount shift computed with plain operators.
   function automatic logic [DATA_W-1:0] ref_model(input logic [2:0] o,
                                                   input logic [DATA_W-1:0] d,
                                                   input int s);
      int r;
      r = s % DATA_W;
      case (o)
         3'd0: return (s >= DATA_W) ? '0 : (d << s);
         3'd1: return (s >= DATA_W) ? '0 : (d >> s);
         3'd2: return (s >= DATA_W) ? {DATA_W{d[DATA_W-1]}} : DATA_W'($signed(d) >>> s);
         3'd3: return (r == 0) ? d : ((d << r) | (d >> (DATA_W - r)));
         3'd4: return (r == 0) ? d : ((d >> r) | (d << (DATA_W - r)));
         default: return d;
      endcase
   endfunction

   // ---------------- driver ----------------
   // Starts one job from IDLE and follows it to completion. Samples at negedge.
   // With noise set, start/op/data/shamt are scrambled while the job runs.
   task automatic run_job(input string tag, input logic [2:0] o,
                          input logic [DATA_W-1:0] d, input int s, input bit noise);
      int idx, done_idx, done_cnt, busy_cnt, exp_idx;
      logic [DATA_W-1:0] res_at_done, exp_res;
      exp_res = ref_model(o, d, s);
      exp_idx = (s == 0 || o > 3'd4) ? 0 : s;
      exp_q.push_back(exp_res);
      @(negedge clk);
      check({tag, "_idle_before"}, {31'd0, busy}, 32'd0);
      start = 1'b1; op = o; data_in = d; shamt_in = SHAMT_W'(s);
      @(negedge clk);
      start = 1'b0;
      idx = 0; done_idx = -1; done_cnt = 0; busy_cnt = 0; res_at_done = 'x;
      while (busy === 1'b1 && idx < 100) begin
         busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_idx = idx;
            res_at_done = result;
         end
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            data_in  = (idx == 0) ? 32'h1234_5678 : $urandom;
            shamt_in = SHAMT_W'($urandom);
            op       = 3'($urandom);
         end
         idx++;
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_no_timeout"}, {31'd0, (idx < 100)}, 32'd1);
      check({tag, "_done_idx"}, done_idx, exp_idx);
      check({tag, "_done_cnt"}, done_cnt, 32'd1);
      check({tag, "_busy_cycles"}, busy_cnt, exp_idx + 1);
      check({tag, "_result"}, res_at_done, exp_q.pop_front());
      check({tag, "_result_held"}, result, exp_res);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int idx, done_cnt;
      reset = 1'b0;
      #12;
      check("rst_result", result, '0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // directed cases
      run_job("sll4",   3'd0, 32'h0000_0001, 4,  0);
      run_job("sra31",  3'd2, 32'h8000_0000, 31, 0);
      run_job("srl31",  3'd1, 32'h8000_0000, 31, 0);
      run_job("rotr4",  3'd4, 32'h0000_00F1, 4,  0);
      run_job("rotl1",  3'd3, 32'h8000_0001, 1,  0);
      run_job("shamt0", 3'd0, 32'hDEAD_BEEF, 0,  0);
      run_job("badop",  3'd7, 32'hDEAD_BEEF, 7,  0);
      run_job("noisy",  3'd0, 32'h0000_0001, 4,  1);

      // start held through DONE: one IDLE cycle then re-accepted
      @(negedge clk);
      start = 1'b1; op = 3'd0; data_in = 32'h0000_0001; shamt_in = 5'd2;
      idx = 0;
      @(negedge clk);
      while (done !== 1'b1 && idx < 20) begin idx++; @(negedge clk); end
      check("hold_first_done", {31'd0, done}, 32'd1);
      check("hold_first_res", result, 32'h0000_0004);
      data_in = 32'h0000_0003;
      @(negedge clk);
      check("hold_idle_gap", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("hold_reaccept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      idx = 0;
      while (done !== 1'b1 && idx < 20) begin idx++; @(negedge clk); end
      check("hold_second_res", result, 32'h0000_000C);
      @(negedge clk);

      // asynchronous reset mid-SHIFT
      @(negedge clk);
      start = 1'b1; op = 3'd0; data_in = 32'h0000_0001; shamt_in = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_result", result, '0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      done_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      check("arst_no_done", done_cnt, 32'd0);
      run_job("post_rst", 3'd3, 32'hF000_000F, 8, 0);

      // randomized jobs
      for (int i = 0; i < 60; i++) begin
         run_job("rand", 3'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle shift unit that sits directly downstream of the shifter entry-select and shift-amount-select muxes in the multicycle MIPS datapath.
- It latches an operand and a shift amount on `start`, then shifts one bit position per clock.
- It raises `done` for one cycle when the result is final. The control FSM waits on `done` before writing `result` to the register file (sll/srl/sra/sllv/srlv/srav).

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W >= DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  shift operation: 000 sll, 001 srl, 010 sra, 011 rotl, 100 rotr; others are pass-through.
- data_in  input  DATA_W  operand from the entry-select mux.
- shamt_in  input  SHAMT_W  shift amount from the amount-select mux.
- result  output  DATA_W  working/final register; valid when done=1, held until the next accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse marking result as final.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, result=0, busy=0, done=0, internal count=0, latched op=000.
  - Reset mid-operation aborts immediately. No done pulse is issued for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge k: result<=data_in, latch op, count<=shamt_in.
  - Next state is SHIFT if shamt_in!=0 and op is valid; otherwise DONE.
  - If start=0: hold; result unchanged.
- SHIFT, at each edge:
  - result is shifted by exactly one position per latched op:
    - sll: {result[DATA_W-2:0],0}
    - srl: {0,result[DATA_W-1:1]}
    - sra: {result[DATA_W-1],result[DATA_W-1:1]}
    - rotl: {result[DATA_W-2:0],result[DATA_W-1]}
    - rotr: {result[0],result[DATA_W-1:1]}
  - count<=count-1. When count==1 at that edge, next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE unconditionally.
- Latency:
  - Start accepted at edge k means done is high during the cycle after edge k+shamt, i.e. shamt+1 cycles after acceptance.
  - shamt=0 or an invalid op gives done in the cycle after edge k, with result=data_in.
- busy=1 in SHIFT and DONE, and is registered with state.
- start while busy=1 is ignored (not queued). Changes on data_in/shamt_in/op after acceptance have no effect.
- start=1 during the DONE cycle is ignored. It is accepted at the next edge only if it is still high in IDLE (earliest back-to-back: one IDLE cycle between jobs).
- shamt values >= DATA_W (possible only when 2^SHAMT_W > DATA_W):
  - Shifts proceed bit-by-bit for the full count.
  - Logical shifts saturate to 0, sra to all sign bits, and rotates wrap modulo DATA_W.
- Intermediate result values are visible during SHIFT. Consumers must use result only when done=1 or after.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start with op=000, data_in=0x0000_0001, shamt=4: done pulses 5 cycles after acceptance, result=0x0000_0010, and busy is high for exactly 5 cycles.
- op=010 (sra), data_in=0x8000_0000, shamt=31 -> result=0xFFFF_FFFF after 32 cycles; then op=001 (srl), same data and shamt -> result=0x0000_0001.
- op=100 (rotr), data_in=0x0000_00F1, shamt=4 -> result=0x1000_000F; op=011 (rotl), data_in=0x8000_0001, shamt=1 -> result=0x0000_0003.
- shamt=0 with data_in=0xDEAD_BEEF, and separately op=111 with shamt=7 -> done in the cycle after acceptance, result=0xDEAD_BEEF in both cases.
- During SHIFT, pulse start with new data_in=0x1234_5678 and change shamt_in: the original job completes unchanged and the second start is ignored. start held high through DONE is accepted only from IDLE.
- Assert reset=0 asynchronously mid-SHIFT (between clock edges) -> result=0, busy=0, done=0 immediately, and no done pulse follows. A new start after reset release completes normally.
